// File: rtl/pwconv_pkg.sv
// rtl/pwconv_pkg.sv - shared geometry constants, bank index type and signed max helper
package pwconv_pkg;

  localparam int DATA_W    = 8;
  localparam int PIXEL_ROW = 18;
  localparam int PIXEL_COL = 2;
  localparam int CH_NUM    = 32;
  localparam int INPUT_NUM = 36;
  localparam int OUT_PIX   = (PIXEL_ROW / 2) * (PIXEL_COL / 2);
  localparam int CNT_W     = $clog2(CH_NUM) + 1;
  localparam int VEC_W     = DATA_W * OUT_PIX;
  localparam int FMAP_W    = VEC_W * CH_NUM;

  typedef logic bank_idx_t;

  function automatic logic [DATA_W-1:0] max2_s(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [DATA_W-1:0] max4_s(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [DATA_W-1:0] c,
                                               input logic [DATA_W-1:0] d);
    return max2_s(max2_s(a, b), max2_s(c, d));
  endfunction

endpackage

// File: rtl/pool_max4.sv
// rtl/pool_max4.sv - combinational 4-input signed max of one 2x2 window
// Optional POOL_RELU_EN clamps negative results to zero.
module pool_max4
  import pwconv_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] c_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] max_o
);

  logic [DATA_W-1:0] max_raw;

  assign max_raw = max4_s(a_i, b_i, c_i, d_i);

`ifdef POOL_RELU_EN
  assign max_o = max_raw[DATA_W-1] ? '0 : max_raw;
`else
  assign max_o = max_raw;
`endif

endmodule

// File: rtl/pwconv_pool_collect.sv
// rtl/pwconv_pool_collect.sv - 2x2 max pool per channel, double-buffered CH_NUM-channel frame collector
// Optional POOL_RELU_EN (in pool_max4) clamps pooled values at zero.
module pwconv_pool_collect
  import pwconv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pool_valid_i,
  input  logic [DATA_W*INPUT_NUM-1:0] pool_pixel_i,
  input  logic                       pool_ready_i,
  output logic                       pool_valid_o,
  output logic [FMAP_W-1:0]          pool_fmap_o,
  output logic [CNT_W-1:0]           pool_ch_cnt_o,
  output logic                       pool_overflow_o
);

  if (INPUT_NUM != PIXEL_ROW * PIXEL_COL || (PIXEL_ROW % 2) != 0 || (PIXEL_COL % 2) != 0)
  begin : g_bad_geometry
    $error("pwconv_pool_collect: INPUT_NUM must equal PIXEL_ROW*PIXEL_COL with even dimensions");
  end

  logic [VEC_W-1:0] pooled;

  for (genvar p = 0; p < OUT_PIX; p++) begin : g_pool
    localparam int PR  = p / (PIXEL_COL / 2);
    localparam int PC  = p % (PIXEL_COL / 2);
    localparam int I00 = (2 * PR) * PIXEL_COL + 2 * PC;
    localparam int I01 = I00 + 1;
    localparam int I10 = I00 + PIXEL_COL;
    localparam int I11 = I10 + 1;

    pool_max4 u_max4 (
      .a_i   (pool_pixel_i[DATA_W*I00 +: DATA_W]),
      .b_i   (pool_pixel_i[DATA_W*I01 +: DATA_W]),
      .c_i   (pool_pixel_i[DATA_W*I10 +: DATA_W]),
      .d_i   (pool_pixel_i[DATA_W*I11 +: DATA_W]),
      .max_o (pooled[DATA_W*p +: DATA_W])
    );
  end

  logic             s1_v_q;
  logic [VEC_W-1:0] s1_vec_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s1_vec_q <= '0;
    end else begin
      s1_v_q <= pool_valid_i;
      if (pool_valid_i) s1_vec_q <= pooled;
    end
  end

  bank_idx_t        wb_q, wb_d;
  bank_idx_t        rb_q, rb_d;
  logic [1:0]       full_q, full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             wr_en;
  logic             last_wr;
  logic             release_rb;

  // Fullness is judged on the registered flags, so a release in the same cycle cannot rescue a write.
  always_comb begin
    wr_en      = s1_v_q && !full_q[wb_q];
    last_wr    = wr_en && (cnt_q == CNT_W'(CH_NUM - 1));
    release_rb = full_q[rb_q] && pool_ready_i;
    full_d     = full_q;
    wb_d       = wb_q;
    rb_d       = rb_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    if (s1_v_q && full_q[wb_q]) ovf_d = 1'b1;
    if (wr_en) cnt_d = cnt_q + CNT_W'(1);
    if (last_wr) begin
      full_d[wb_q] = 1'b1;
      wb_d         = ~wb_q;
      cnt_d        = '0;
    end
    if (release_rb) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      full_q <= 2'b00;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  logic [FMAP_W-1:0] bank_q [2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
    end else if (wr_en) begin
      bank_q[wb_q][VEC_W*cnt_q[CNT_W-2:0] +: VEC_W] <= s1_vec_q;
    end
  end

  assign pool_valid_o    = full_q[rb_q];
  assign pool_fmap_o     = bank_q[rb_q];
  assign pool_ch_cnt_o   = cnt_q;
  assign pool_overflow_o = ovf_q;

endmodule

// File: tb/tb_pwconv_pool_collect.sv
// tb/tb_pwconv_pool_collect.sv - scoreboard bench for pwconv_pool_collect
module tb_pwconv_pool_collect;

  localparam int DW   = 8;
  localparam int NIN  = 36;
  localparam int NOUT = 9;
  localparam int NCH  = 32;
  localparam int VW   = DW * NOUT;
  localparam int FW   = VW * NCH;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pool_valid_i = 1'b0;
  logic              pool_ready_i = 1'b0;
  logic [DW*NIN-1:0] pool_pixel_i = '0;
  logic              pool_valid_o;
  logic [FW-1:0]     pool_fmap_o;
  logic [5:0]        pool_ch_cnt_o;
  logic              pool_overflow_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] acc;
  int            acc_cnt;

  pwconv_pool_collect dut (
    .clk             (clk),
    .rst             (rst),
    .pool_valid_i    (pool_valid_i),
    .pool_pixel_i    (pool_pixel_i),
    .pool_ready_i    (pool_ready_i),
    .pool_valid_o    (pool_valid_o),
    .pool_fmap_o     (pool_fmap_o),
    .pool_ch_cnt_o   (pool_ch_cnt_o),
    .pool_overflow_o (pool_overflow_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] pool_model(input logic [DW*NIN-1:0] px);
    logic [VW-1:0] r;
    int best, v, idx;
    r = '0;
    for (int p = 0; p < NOUT; p++) begin
      best = -1000;
      for (int dr = 0; dr < 2; dr++) begin
        for (int dc = 0; dc < 2; dc++) begin
          idx = (2 * p + dr) * 2 + dc;
          v = int'($signed(px[DW*idx +: DW]));
          if (v > best) best = v;
        end
      end
`ifdef POOL_RELU_EN
      if (best < 0) best = 0;
`endif
      r[DW*p +: DW] = best[7:0];
    end
    return r;
  endfunction

  function automatic logic [DW*NIN-1:0] pix_pattern(input int base);
    logic [DW*NIN-1:0] px;
    for (int i = 0; i < NIN; i++) px[DW*i +: DW] = 8'((base + i) % 100);
    return px;
  endfunction

  function automatic logic [FW-1:0] exp_front();
    if (exp_q.size() == 0) return 'x;
    return exp_q[0];
  endfunction

  task automatic model_clear();
    exp_q.delete();
    acc     = '0;
    acc_cnt = 0;
  endtask

  // Drives one channel pulse; when modelled, the expected pooled vector joins the frame being built.
  task automatic send_ch(input logic [DW*NIN-1:0] px, input bit model);
    pool_pixel_i = px;
    pool_valid_i = 1'b1;
    tick();
    pool_valid_i = 1'b0;
    if (model) begin
      acc[VW*acc_cnt +: VW] = pool_model(px);
      acc_cnt++;
      if (acc_cnt == NCH) begin
        exp_q.push_back(acc);
        acc     = '0;
        acc_cnt = 0;
      end
    end
  endtask

  task automatic send_frame(input int base);
    for (int ch = 0; ch < NCH; ch++) send_ch(pix_pattern(base + ch), 1'b1);
  endtask

  task automatic pulse_ready();
    pool_ready_i = 1'b1;
    tick();
    pool_ready_i = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", pool_valid_o); end
    n_tests++; if (pool_overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", pool_overflow_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", pool_ch_cnt_o); end
    n_tests++; if (pool_fmap_o !== '0) begin n_fail++; $display("FAIL reset_fmap got nonzero exp=0"); end
    rst = 1'b0;
    model_clear();
    tick();
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=0", pool_valid_o); end
  endtask

  task automatic test_single_frame();
    logic [7:0] b;
    send_frame(0);
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_not_early got=%b exp=0", pool_valid_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd31) begin n_fail++; $display("FAIL single_cnt31 got=%0d exp=31", pool_ch_cnt_o); end
    tick();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL single_cnt0 got=%0d exp=0", pool_ch_cnt_o); end
    n_tests++; if (pool_overflow_o !== 1'b0) begin n_fail++; $display("FAIL single_ovf got=%b exp=0", pool_overflow_o); end
    b = pool_fmap_o[7:0];
    n_tests++; if (b !== 8'd3) begin n_fail++; $display("FAIL single_ch0_p0 got=%0d exp=3", b); end
    b = pool_fmap_o[FW-8 +: 8];
    n_tests++; if (b !== 8'd66) begin n_fail++; $display("FAIL single_ch31_p8 got=%0d exp=66", b); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL single_frame got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_released got=%b exp=0", pool_valid_o); end
  endtask

  task automatic test_negative();
    logic [DW*NIN-1:0] px;
    logic [7:0] b, exp_b;
    for (int ch = 0; ch < NCH; ch++) begin
      for (int i = 0; i < NIN; i++) px[DW*i +: DW] = 8'($urandom_range(0, 255));
      if (ch == 0) px[31:0] = {8'hFF, 8'hF8, 8'hFD, 8'hFB};
      send_ch(px, 1'b1);
    end
    tick();
`ifdef POOL_RELU_EN
    exp_b = 8'h00;
`else
    exp_b = 8'hFF;
`endif
    b = pool_fmap_o[7:0];
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL neg_valid got=%b exp=1", pool_valid_o); end
    n_tests++; if (b !== exp_b) begin n_fail++; $display("FAIL neg_ch0_p0 got=%h exp=%h", b, exp_b); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL neg_frame got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
  endtask

  task automatic test_backpressure();
    send_frame(0);
    send_frame(50);
    tick();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL bp_cnt got=%0d exp=0", pool_ch_cnt_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL bp_frame1 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    repeat (3) tick();
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL bp_stable got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    send_ch(pix_pattern(77), 1'b0);
    tick();
    n_tests++; if (pool_overflow_o !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got=%b exp=1", pool_overflow_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL bp_drop_cnt got=%0d exp=0", pool_ch_cnt_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL bp_drop_frame got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
  endtask

  task automatic test_drain_refill();
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL dr_frame1 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL dr_valid2 got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL dr_frame2 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    send_ch(pix_pattern(11), 1'b1);
    tick();
    n_tests++; if (pool_ch_cnt_o !== 6'd1) begin n_fail++; $display("FAIL dr_refill_cnt got=%0d exp=1", pool_ch_cnt_o); end
    for (int ch = 1; ch < NCH; ch++) send_ch(pix_pattern(11 + ch), 1'b1);
    tick();
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL dr_frame2_held got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL dr_valid3 got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL dr_frame3 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL dr_empty got=%b exp=0", pool_valid_o); end
  endtask

  task automatic test_same_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    send_frame(7);
    tick();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL sc_valid0 got=%b exp=1", pool_valid_o); end
    send_frame(20);
    // The final channel is now in stage 1; its write lands on the same edge as the handshake.
    pool_ready_i = 1'b1;
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL sc_bank0 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    tick();
    pool_ready_i = 1'b0;
    void'(exp_q.pop_front());
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL sc_valid1 got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL sc_bank1 got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    n_tests++; if (pool_overflow_o !== 1'b0) begin n_fail++; $display("FAIL sc_ovf got=%b exp=0", pool_overflow_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL sc_cnt got=%0d exp=0", pool_ch_cnt_o); end
    pulse_ready();
  endtask

  task automatic test_reset_mid();
    send_frame(3);
    tick();
    for (int ch = 0; ch < 10; ch++) send_ch(pix_pattern(40 + ch), 1'b0);
    rst = 1'b1;
    #1;
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_valid got=%b exp=0", pool_valid_o); end
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL rm_cnt got=%0d exp=0", pool_ch_cnt_o); end
    n_tests++; if (pool_fmap_o !== '0) begin n_fail++; $display("FAIL rm_fmap got nonzero exp=0"); end
    tick();
    rst = 1'b0;
    model_clear();
    tick();
    n_tests++; if (pool_ch_cnt_o !== 6'd0) begin n_fail++; $display("FAIL rm_inflight_cnt got=%0d exp=0", pool_ch_cnt_o); end
    send_frame(60);
    tick();
    n_tests++; if (pool_valid_o !== 1'b1) begin n_fail++; $display("FAIL rm_after_valid got=%b exp=1", pool_valid_o); end
    n_tests++; if (pool_fmap_o !== exp_front()) begin n_fail++; $display("FAIL rm_after_frame got=%h exp=%h", pool_fmap_o[VW-1:0], exp_front() & VW'('1)); end
    pulse_ready();
    n_tests++; if (pool_valid_o !== 1'b0) begin n_fail++; $display("FAIL rm_drained got=%b exp=0", pool_valid_o); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_frame();
    test_negative();
    test_backpressure();
    test_drain_refill();
    test_same_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
